// File: rtl/pe_weight_loader_pkg.sv
// Shared PE weight-path definitions: per-layer weight address map, the
// sequencer state encoding and small sizing helpers.
package pe_weight_loader_pkg;

  // Weight address map: first kernel write address of each layer's PE.
  localparam logic [31:0] LAYER0_WEIGHT_BASE = 32'd23;
  localparam logic [31:0] LAYER1_WEIGHT_BASE = 32'd249;
  localparam logic [31:0] LAYER2_WEIGHT_BASE = 32'd1024;

  // Sequencer state encoding. A future weight readback block walks the
  // same sections, so the encoding is kept here rather than in the loader.
  typedef logic [1:0] pe_wl_state_t;
  localparam pe_wl_state_t ST_IDLE   = 2'd0;
  localparam pe_wl_state_t ST_KERNEL = 2'd1;
  localparam pe_wl_state_t ST_WORD   = 2'd2;
  localparam pe_wl_state_t ST_DONE   = 2'd3;

  // Number of 32-bit stream words that carry n packed kernel bytes.
  function automatic int ceil_div4(input int n);
    return (n + 3) / 4;
  endfunction

endpackage

// File: rtl/weight_byte_unpacker.sv
// Holds one stream word and hands it to the sequencer one write at a time:
// four (or fewer, for the partial last kernel word) zero-extended bytes in
// the kernel section, or the whole word in the word section.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready. On the output side "ready" is
// the en input: while en is high the sequencer takes every offered write.
module weight_byte_unpacker
  import pe_weight_loader_pkg::*;
#(
  parameter int NUM_KERNEL_WEIGHTS = 216,
  parameter int NUM_WORD_WEIGHTS   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last
);

  localparam int KW    = ceil_div4(NUM_KERNEL_WEIGHTS);
  localparam int TOTAL = KW + NUM_WORD_WEIGHTS;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] KW_C      = CW'(KW);
  localparam logic [CW-1:0] KW_M1_C   = CW'(KW - 1);
  localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);
  // Index of the last valid byte in the final kernel word.
  localparam logic [1:0]    LAST_KIDX = 2'((NUM_KERNEL_WEIGHTS - 1) % 4);

  logic [31:0]   hold_data_q, hold_data_d;
  logic          hold_valid_q, hold_valid_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    last_idx_q, last_idx_d;
  logic          word_mode_q, word_mode_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          need_more;
  logic          accept;
  logic [7:0]    sel_byte;

  // Holding register, byte index and accepted-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      idx_q        <= '0;
      last_idx_q   <= '0;
      word_mode_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      idx_q        <= idx_d;
      last_idx_q   <= last_idx_d;
      word_mode_q  <= word_mode_d;
      cnt_q        <= cnt_d;
    end
  end

  // Stream-side ready and the write currently offered to the sequencer.
  always_comb begin
    need_more = (cnt_q < TOTAL_C);
    out_valid = hold_valid_q;
    out_last  = (idx_q == last_idx_q);
    // A new word may enter in the same cycle the held word emits its last write.
    s_ready   = en && need_more && (!hold_valid_q || out_last);
    accept    = s_valid && s_ready;
    sel_byte  = hold_data_q[{idx_q, 3'b000} +: 8];
    if (!hold_valid_q) begin
      out_data = '0;
    end else if (word_mode_q) begin
      out_data = hold_data_q;
    end else begin
      out_data = {24'd0, sel_byte};
    end
  end

  // Load a new word, step through its bytes, or release it after the last one.
  always_comb begin
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    idx_d        = idx_q;
    last_idx_d   = last_idx_q;
    word_mode_d  = word_mode_q;
    cnt_d        = cnt_q;
    if (clear) begin
      hold_valid_d = 1'b0;
      idx_d        = '0;
      cnt_d        = '0;
    end else if (accept) begin
      hold_data_d  = s_data;
      hold_valid_d = 1'b1;
      idx_d        = '0;
      cnt_d        = cnt_q + 1'b1;
      // The word's position in the load decides how many writes it yields.
      if (cnt_q >= KW_C) begin
        word_mode_d = 1'b1;
        last_idx_d  = 2'd0;
      end else if (cnt_q == KW_M1_C) begin
        word_mode_d = 1'b0;
        last_idx_d  = LAST_KIDX;
      end else begin
        word_mode_d = 1'b0;
        last_idx_d  = 2'd3;
      end
    end else if (hold_valid_q && en) begin
      if (out_last) begin
        hold_valid_d = 1'b0;
        idx_d        = '0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/pe_weight_loader.sv
// Sequences one weight load into a PE write port: kernel bytes first, then
// the 32-bit bias/coefficient/scale words, at contiguous addresses from
// BASE_ADDR. The write port is driven straight from the holding register,
// so a word accepted in cycle t shows its first write in cycle t+1.
module pe_weight_loader
  import pe_weight_loader_pkg::*;
#(
  parameter int          NUM_KERNEL_WEIGHTS = 216,
  parameter int          NUM_WORD_WEIGHTS   = 10,
  parameter logic [31:0] BASE_ADDR          = LAYER0_WEIGHT_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] weight_wr_data,
  output logic [31:0] weight_wr_addr,
  output logic        weight_wr_en,
  output logic        busy,
  output logic        done
);

  localparam int KCW = $clog2(NUM_KERNEL_WEIGHTS + 1);
  localparam int WCW = $clog2(NUM_WORD_WEIGHTS + 1);
  localparam logic [KCW-1:0] KLAST = KCW'(NUM_KERNEL_WEIGHTS - 1);
  localparam logic [WCW-1:0] WLAST = WCW'(NUM_WORD_WEIGHTS - 1);

  pe_wl_state_t   state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [KCW-1:0] kcnt_q, kcnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;

  logic        en;
  logic        clear;
  logic        fire;
  logic        byte_valid;
  logic        byte_last;
  logic [31:0] byte_data;

  weight_byte_unpacker #(
    .NUM_KERNEL_WEIGHTS(NUM_KERNEL_WEIGHTS),
    .NUM_WORD_WEIGHTS  (NUM_WORD_WEIGHTS)
  ) u_unpacker (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .en       (en),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .out_valid(byte_valid),
    .out_data (byte_data),
    .out_last (byte_last)
  );

  // State register plus address and section counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      kcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      kcnt_q  <= kcnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state: leave a section once its last write has been issued.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    kcnt_d  = kcnt_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_KERNEL;
          addr_d  = BASE_ADDR;
          kcnt_d  = '0;
          wcnt_d  = '0;
        end
      end
      ST_KERNEL: begin
        if (fire) begin
          addr_d = addr_q + 32'd1;
          kcnt_d = kcnt_q + 1'b1;
          if (kcnt_q == KLAST) state_d = ST_WORD;
        end
      end
      ST_WORD: begin
        if (fire) begin
          addr_d = addr_q + 32'd1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WLAST) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: a write fires whenever a held word is available in an active section.
  always_comb begin
    en             = (state_q == ST_KERNEL) || (state_q == ST_WORD);
    clear          = (state_q == ST_IDLE) && start;
    fire           = en && byte_valid;
    busy           = en;
    done           = (state_q == ST_DONE);
    weight_wr_en   = fire;
    weight_wr_addr = addr_q;
    weight_wr_data = byte_data;
  end

endmodule

// File: tb/tb_pe_weight_loader.sv
// Bench for pe_weight_loader: unit 0 uses the default sizes, unit 1 a short
// kernel (6 bytes) with 2 trailing words. Each unit has its own stream of
// words 0x04030201, 0x08070605, ... and a reference write list.
module tb_pe_weight_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start   [2];
  logic [31:0] s_data  [2];
  logic        s_valid [2];
  logic        s_ready [2];
  logic [31:0] wr_data [2];
  logic [31:0] wr_addr [2];
  logic        wr_en   [2];
  logic        busy    [2];
  logic        done    [2];

  int nk   [2] = '{216, 6};
  int nw   [2] = '{10, 2};
  int base [2] = '{23, 23};
  int ptr  [2] = '{0, 0};

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  int first_wr_cyc;
  int last_wr_cyc;

  pe_weight_loader dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .s_data(s_data[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .weight_wr_data(wr_data[0]),
    .weight_wr_addr(wr_addr[0]), .weight_wr_en(wr_en[0]), .busy(busy[0]),
    .done(done[0])
  );

  pe_weight_loader #(
    .NUM_KERNEL_WEIGHTS(6), .NUM_WORD_WEIGHTS(2), .BASE_ADDR(32'd23)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .s_data(s_data[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .weight_wr_data(wr_data[1]),
    .weight_wr_addr(wr_addr[1]), .weight_wr_en(wr_en[1]), .busy(busy[1]),
    .done(done[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Stream word i carries bytes 4i+1 .. 4i+4, little-endian.
  function automatic logic [31:0] word_val(input int i);
    return {8'(4*i + 4), 8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1)};
  endfunction

  task automatic check_idle_outputs(input int u, input string tag);
    check({tag, "_s_ready"}, {31'd0, s_ready[u]}, 32'd0);
    check({tag, "_wr_en"},   {31'd0, wr_en[u]},   32'd0);
    check({tag, "_wr_addr"}, wr_addr[u],          32'd0);
    check({tag, "_wr_data"}, wr_data[u],          32'd0);
    check({tag, "_busy"},    {31'd0, busy[u]},    32'd0);
    check({tag, "_done"},    {31'd0, done[u]},    32'd0);
  endtask

  // Expected (addr, data) list for a load whose first stream word is w0.
  task automatic fill_exp(input int u, input int w0);
    logic [31:0] wv;
    int kw;
    exp_q.delete();
    for (int k = 0; k < nk[u]; k++) begin
      wv = word_val(w0 + k / 4);
      exp_q.push_back({32'(base[u] + k), 24'd0, wv[8*(k%4) +: 8]});
    end
    kw = (nk[u] + 3) / 4;
    for (int w = 0; w < nw[u]; w++)
      exp_q.push_back({32'(base[u] + nk[u] + w), word_val(w0 + kw + w)});
  endtask

  // One load on unit u. abort_at >= 0 raises rst during that write;
  // busy_start_at >= 0 pulses start mid-load at that loop cycle.
  task automatic run_load(input int u, input int valid_pct, input int abort_at,
                          input int busy_start_at, output int nwrites);
    logic [63:0] e;
    bit fin;
    bit aborted;
    fill_exp(u, ptr[u]);
    cap_addr.delete();
    cap_data.delete();
    nwrites = 0;
    fin = 0;
    aborted = 0;
    first_wr_cyc = -1;
    last_wr_cyc = -1;
    @(negedge clk);
    start[u] = 1'b1;
    s_valid[u] = 1'b0;
    @(negedge clk);
    start[u] = 1'b0;
    #1;
    check("busy_after_start", {31'd0, busy[u]}, 32'd1);
    check("ready_after_start", {31'd0, s_ready[u]}, 32'd1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_valid[u] = ($urandom_range(99) < valid_pct);
      s_data[u] = word_val(ptr[u]);
      start[u] = (cyc == busy_start_at);
      #1;
      if (wr_en[u]) begin
        if (exp_q.size() == 0) begin
          check("extra_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr[u], e[63:32]);
          check("wr_data", wr_data[u], e[31:0]);
        end
        cap_addr.push_back(wr_addr[u]);
        cap_data.push_back(wr_data[u]);
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        if (nwrites == abort_at) begin
          rst = 1'b1;
          s_valid[u] = 1'b0;
          aborted = 1;
        end
        nwrites++;
      end
      if (done[u]) begin
        check("done_after_last_write", 32'(cyc - last_wr_cyc), 32'd1);
        check("busy_low_at_done", {31'd0, busy[u]}, 32'd0);
        fin = 1;
      end
      if (s_valid[u] && s_ready[u]) ptr[u]++;
      @(negedge clk);
      if (aborted) begin
        rst = 1'b0;
        #1;
        check_idle_outputs(u, "after_abort");
        exp_q.delete();
        break;
      end
      if (fin) begin
        #1;
        check("done_one_cycle", {31'd0, done[u]}, 32'd0);
        break;
      end
    end
    start[u] = 1'b0;
    s_valid[u] = 1'b0;
    if (!fin && !aborted) check("load_timeout", 32'd0, 32'd1);
    if (!aborted) check("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int p0;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0;
      s_valid[u] = 1'b0;
      s_data[u] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs(0, "reset_a");
    check_idle_outputs(1, "reset_b");

    // Default sizes, stream always valid.
    run_load(0, 100, -1, -1, n);
    check("a_write_count", 32'(n), 32'd226);
    check("a_words_used", 32'(ptr[0]), 32'd64);
    check("a_first_latency", 32'(first_wr_cyc), 32'd1);
    check("a_back_to_back", 32'(last_wr_cyc - first_wr_cyc), 32'd225);
    if (n == 226) begin
      check("a_w0_addr", cap_addr[0], 32'd23);
      check("a_w0_data", cap_data[0], 32'h01);
      check("a_w3_addr", cap_addr[3], 32'd26);
      check("a_w3_data", cap_data[3], 32'h04);
      check("a_w4_addr", cap_addr[4], 32'd27);
      check("a_w4_data", cap_data[4], 32'h05);
      check("a_klast_data", cap_data[215], 32'hD8);
      check("a_word0_addr", cap_addr[216], 32'd239);
      check("a_word0_data", cap_data[216], 32'hDCDBDAD9);
      check("a_wordlast_addr", cap_addr[225], 32'd248);
      check("a_wordlast_data", cap_data[225], 32'h00FFFEFD);
    end

    // Words offered after completion are not taken.
    for (int i = 0; i < 4; i++) begin
      s_valid[0] = 1'b1;
      s_data[0] = word_val(ptr[0]);
      #1;
      check("idle_ready_low", {31'd0, s_ready[0]}, 32'd0);
      check("idle_no_write", {31'd0, wr_en[0]}, 32'd0);
      @(negedge clk);
    end
    s_valid[0] = 1'b0;

    // Short kernel with a partial last word.
    run_load(1, 100, -1, -1, n);
    check("b_write_count", 32'(n), 32'd8);
    check("b_words_used", 32'(ptr[1]), 32'd4);
    if (n == 8) begin
      check("b_k5_addr", cap_addr[5], 32'd28);
      check("b_k5_data", cap_data[5], 32'h06);
      check("b_word0_addr", cap_addr[6], 32'd29);
      check("b_word0_data", cap_data[6], 32'h0C0B0A09);
      check("b_word1_data", cap_data[7], 32'h100F0E0D);
    end

    // Random stream gaps with a start pulse while busy.
    run_load(0, 50, -1, 37, n);
    check("gap_write_count", 32'(n), 32'd226);
    run_load(1, 40, -1, 3, n);
    check("b_gap_write_count", 32'(n), 32'd8);

    // Abort during write 100, then restart from the next stream word.
    run_load(0, 100, 100, -1, n);
    check("abort_write_count", 32'(n), 32'd101);
    p0 = ptr[0];
    run_load(0, 100, -1, -1, n);
    check("restart_write_count", 32'(n), 32'd226);
    if (n == 226) begin
      check("restart_addr", cap_addr[0], 32'd23);
      check("restart_data", cap_data[0], {24'd0, 8'(4*p0 + 1)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
